calc_core_param: RTL and testbench

Parametrised successor to the fixed 16-bit keypad calculator core. It accepts decoded keypad events and holds the operand and accumulator registers. It performs add, subtract and a sequential multiply on sign-magnitude numbers of configurable width, and drives magnitude, sign, overflow and busy status to the display path. It sits between the keypad scanner and the seven-segment display driver.

---
 rtl/calc_pkg.sv | 23 ++
 rtl/calc_core_param_if.sv | 12 +
 rtl/calc_mul_seq.sv | 78 +++++++
 rtl/calc_core_param.sv | 196 +++++++++++++++++++
 tb/tb_calc_core_param.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared keycodes, operator and state encodings for the keypad calculator core.
package calc_pkg;

  localparam logic [4:0] KEY_ADD = 5'h10;
  localparam logic [4:0] KEY_SUB = 5'h11;
  localparam logic [4:0] KEY_MUL = 5'h12;
  localparam logic [4:0] KEY_NEG = 5'h13;
  localparam logic [4:0] KEY_EQ  = 5'h14;
  localparam logic [4:0] KEY_CLR = 5'h15;

  typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL} op_t;
  typedef enum logic [1:0] {ST_ENTRY, ST_COMPUTE, ST_RESULT} state_t;

  function automatic op_t key_to_op(input logic [4:0] key);
    case (key)
      KEY_ADD: return OP_ADD;
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/calc_core_param_if.sv
// Keypad-event input and display-status output bundle of the calculator core.
interface calc_core_param_if #(parameter int WIDTH = 16);
  logic             newkey;
  logic [4:0]       keycode;
  logic [WIDTH-1:0] display;
  logic             sign;
  logic             ovw;
  logic             busy;

  modport master (output newkey, keycode, input display, sign, ovw, busy);
  modport slave  (input newkey, keycode, output display, sign, ovw, busy);
endinterface

// File: rtl/calc_mul_seq.sv
// Shift-add magnitude multiplier: one partial product per cycle, the first
// one taken on the start edge so done pulses exactly WIDTH cycles later.
module calc_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             done_q, done_d;

  // One iteration: conditionally add the multiplicand, then shift {carry,hi,lo} right.
  function automatic logic [2*WIDTH-1:0] step(input logic [WIDTH-1:0] hi,
                                              input logic [WIDTH-1:0] lo,
                                              input logic [WIDTH-1:0] mc);
    logic [WIDTH:0] sum;
    sum = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
    return {sum, lo[WIDTH-1:1]};
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    done_d  = 1'b0;
    if (start) begin
      mcand_d      = a;
      {hi_d, lo_d} = step('0, b, a);
      cnt_d        = CNT_W'(WIDTH - 1);
      run_d        = 1'b1;
    end else if (run_q) begin
      {hi_d, lo_d} = step(hi_q, lo_q, mcand_q);
      cnt_d        = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      done_q  <= done_d;
    end
  end

  assign done    = done_q;
  assign product = {hi_q, lo_q};

endmodule

// File: rtl/calc_core_param.sv
// Sign-magnitude keypad calculator core: operand entry, chained add/sub/mul,
// overflow tracking and display selection.
module calc_core_param
  import calc_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = WIDTH / 4
) (
  input  logic              clock,
  input  logic              reset,
  calc_core_param_if.slave  bus
);

  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] DIGITS_C = CNT_W'(DIGITS);

  typedef struct packed {
    logic             neg;
    logic [WIDTH-1:0] mag;
  } sm_t;

  function automatic sm_t norm(input logic neg, input logic [WIDTH-1:0] mag);
    sm_t r;
    r.neg = neg & (|mag);
    r.mag = mag;
    return r;
  endfunction

  state_t           state_q, state_d;
  sm_t              entry_q, entry_d, acc_q, acc_d, disp_q, disp_d;
  op_t              pend_q, pend_d, after_q, after_d;
  logic             ovw_q, ovw_d, show_acc_q, show_acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic               mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  calc_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (acc_q.mag),
    .b       (entry_q.mag),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Sign-magnitude add/sub on WIDTH+1 bits; the larger magnitude sets the sign.
  logic           b_neg, as_neg, as_ovf, mul_ovf;
  logic [WIDTH:0] as_mag;
  sm_t            as_res, mul_res;

  always_comb begin
    b_neg  = entry_q.neg ^ (pend_q == OP_SUB);
    as_neg = acc_q.neg;
    if (acc_q.neg == b_neg) begin
      as_mag = {1'b0, acc_q.mag} + {1'b0, entry_q.mag};
    end else if (acc_q.mag >= entry_q.mag) begin
      as_mag = {1'b0, acc_q.mag} - {1'b0, entry_q.mag};
    end else begin
      as_mag = {1'b0, entry_q.mag} - {1'b0, acc_q.mag};
      as_neg = b_neg;
    end
    as_ovf  = as_mag[WIDTH];
    as_res  = norm(as_neg, as_mag[WIDTH-1:0]);
    mul_ovf = |mul_prod[2*WIDTH-1:WIDTH];
    mul_res = norm(acc_q.neg ^ entry_q.neg, mul_prod[WIDTH-1:0]);
  end

  logic key_ok, is_digit, is_op, fin, fin_ovf;
  op_t  key_op, fin_next;
  sm_t  fin_val;

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    acc_d      = acc_q;
    pend_d     = pend_q;
    after_d    = after_q;
    ovw_d      = ovw_q;
    show_acc_d = show_acc_q;
    cnt_d      = cnt_q;
    mul_start  = 1'b0;
    fin        = 1'b0;
    fin_next   = OP_NONE;
    fin_val    = acc_q;
    fin_ovf    = 1'b0;
    key_ok     = bus.newkey && (state_q != ST_COMPUTE);
    is_digit   = ~bus.keycode[4];
    key_op     = key_to_op(bus.keycode);
    is_op      = (key_op != OP_NONE);

    case (state_q)
      ST_ENTRY: if (key_ok) begin
        if (is_digit) begin
          show_acc_d = 1'b0;
          if (cnt_q < DIGITS_C) begin
            entry_d.mag = {entry_q.mag[WIDTH-5:0], bus.keycode[3:0]};
            cnt_d       = cnt_q + CNT_W'(1);
          end
        end else if (bus.keycode == KEY_NEG) begin
          entry_d.neg = ~entry_q.neg;
          show_acc_d  = 1'b0;
        end else if (is_op || bus.keycode == KEY_EQ) begin
          if (pend_q == OP_MUL) begin
            mul_start = 1'b1;
            after_d   = key_op;
            state_d   = ST_COMPUTE;
          end else begin
            fin      = 1'b1;
            fin_next = key_op;
            fin_ovf  = (pend_q != OP_NONE) && as_ovf;
            fin_val  = (pend_q == OP_NONE) ? norm(entry_q.neg, entry_q.mag) : as_res;
          end
        end
      end
      ST_COMPUTE: if (mul_done) begin
        fin      = 1'b1;
        fin_next = after_q;
        fin_val  = mul_res;
        fin_ovf  = mul_ovf;
      end
      ST_RESULT: if (key_ok) begin
        if (is_digit) begin
          acc_d              = '0;
          ovw_d              = 1'b0;
          entry_d            = '0;
          entry_d.mag[3:0]   = bus.keycode[3:0];
          cnt_d              = CNT_W'(1);
          show_acc_d         = 1'b0;
          state_d            = ST_ENTRY;
        end else if (is_op) begin
          pend_d  = key_op;
          state_d = ST_ENTRY;
        end else if (bus.keycode == KEY_NEG) begin
          acc_d.neg = ~acc_q.neg & (|acc_q.mag);
        end
      end
      default: state_d = ST_ENTRY;
    endcase

    // A finished operation lands in acc; a trailing op key keeps entering, EQ shows the result.
    if (fin) begin
      acc_d      = fin_val;
      ovw_d      = ovw_q | fin_ovf;
      pend_d     = fin_next;
      state_d    = (fin_next == OP_NONE) ? ST_RESULT : ST_ENTRY;
      entry_d    = '0;
      cnt_d      = '0;
      show_acc_d = 1'b1;
    end

    if (key_ok && bus.keycode == KEY_CLR) begin
      state_d    = ST_ENTRY;
      entry_d    = '0;
      acc_d      = '0;
      pend_d     = OP_NONE;
      after_d    = OP_NONE;
      ovw_d      = 1'b0;
      show_acc_d = 1'b0;
      cnt_d      = '0;
    end

    disp_d = (state_d == ST_COMPUTE) ? disp_q : (show_acc_d ? acc_d : entry_d);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_ENTRY;
      entry_q    <= '0;
      acc_q      <= '0;
      disp_q     <= '0;
      pend_q     <= OP_NONE;
      after_q    <= OP_NONE;
      ovw_q      <= 1'b0;
      show_acc_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      acc_q      <= acc_d;
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      after_q    <= after_d;
      ovw_q      <= ovw_d;
      show_acc_q <= show_acc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.display = disp_q.mag;
  assign bus.sign    = disp_q.neg;
  assign bus.ovw     = ovw_q;
  assign bus.busy    = (state_q == ST_COMPUTE);

endmodule

// File: tb/tb_calc_core_param.sv
// Scoreboard bench for calc_core_param at WIDTH=16: keypad sequences, multiply
// timing, busy drop, chaining, entry limit, async reset and a random add/sub model.
module tb_calc_core_param;
  import calc_pkg::*;

  localparam int WIDTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  calc_core_param_if #(.WIDTH(WIDTH)) bus();

  calc_core_param #(.WIDTH(WIDTH)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] disp;
    logic             sgn;
    logic             ov;
    logic             bsy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Caller is always at a negedge; the key is sampled on the following posedge.
  task automatic press(input logic [4:0] k);
    bus.newkey  = 1'b1;
    bus.keycode = k;
    @(negedge clk);
    bus.newkey  = 1'b0;
  endtask

  task automatic push_exp(input string tag, input logic [WIDTH-1:0] d,
                          input logic s, input logic o, input logic b);
    exp_t e;
    e.tag = tag; e.disp = d; e.sgn = s; e.ov = o; e.bsy = b;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = exp_q.pop_front();
      check({e.tag, ".display"}, 32'(bus.display), 32'(e.disp));
      check({e.tag, ".sign"},    32'(bus.sign),    32'(e.sgn));
      check({e.tag, ".ovw"},     32'(bus.ovw),     32'(e.ov));
      check({e.tag, ".busy"},    32'(bus.busy),    32'(e.bsy));
    end
  endtask

  task automatic key_chk(input logic [4:0] k, input string tag, input logic [WIDTH-1:0] d,
                         input logic s, input logic o, input logic b);
    push_exp(tag, d, s, o, b);
    press(k);
    pop_cmp();
  endtask

  task automatic type_hex(input logic [15:0] v);
    for (int i = 3; i >= 0; i--) press({1'b0, v[i*4 +: 4]});
  endtask

  // Counts busy cycles (bounded); optionally drives a digit key mid-busy.
  task automatic run_mul(input int inject_at, output int cycles);
    cycles = 0;
    for (int i = 0; i < 100; i++) begin
      if (!bus.busy) break;
      cycles++;
      if (i == inject_at) begin
        bus.newkey  = 1'b1;
        bus.keycode = 5'h07;
      end
      @(negedge clk);
      bus.newkey = 1'b0;
    end
  endtask

  logic [15:0] am, bm, em;
  logic        an, bn, sub, es, eo;
  int          av, bv, rv, mag, cyc;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.newkey  = 1'b0;
    bus.keycode = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_exp("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    pop_cmp();

    // Basic add
    key_chk(5'h01,   "add_d1",  16'h0001, 0, 0, 0);
    key_chk(5'h02,   "add_d2",  16'h0012, 0, 0, 0);
    key_chk(KEY_ADD, "add_op",  16'h0012, 0, 0, 0);
    key_chk(5'h03,   "add_d3",  16'h0003, 0, 0, 0);
    press(5'h04);
    key_chk(KEY_EQ,  "add_eq",  16'h0046, 0, 0, 0);

    // Subtract to a negative result, then NEG in RESULT
    key_chk(KEY_CLR, "clr1",    16'h0000, 0, 0, 0);
    press(5'h05);
    press(KEY_SUB);
    press(5'h09);
    key_chk(KEY_EQ,  "sub_eq",  16'h0004, 1, 0, 0);
    key_chk(KEY_NEG, "sub_neg", 16'h0004, 0, 0, 0);

    // Overflow wraps to zero with no negative zero; a digit clears ovw
    press(KEY_CLR);
    type_hex(16'hFFFF);
    key_chk(KEY_ADD, "ovf_op",  16'hFFFF, 0, 0, 0);
    press(5'h01);
    key_chk(KEY_EQ,  "ovf_eq",  16'h0000, 0, 1, 0);
    key_chk(5'h07,   "ovf_dig", 16'h0007, 0, 0, 0);

    // Multiply: busy length, display hold, result
    press(KEY_CLR);
    press(5'h01); press(5'h02); press(KEY_MUL); press(5'h03); press(5'h04);
    key_chk(KEY_EQ,  "mul_start", 16'h0034, 0, 0, 1);
    push_exp("mul_res", 16'h03A8, 0, 0, 0);
    run_mul(-1, cyc);
    check("mul_busy_len", 32'(cyc + 1), 32'd17);
    pop_cmp();

    // Multiply with a digit dropped mid-busy; next key accepted as busy falls
    press(KEY_CLR);
    press(5'h01); press(5'h02); press(KEY_MUL); press(5'h03); press(5'h04);
    press(KEY_EQ);
    push_exp("mul_drop", 16'h03A8, 0, 0, 0);
    run_mul(5, cyc);
    check("mul_drop_len", 32'(cyc), 32'd16);
    pop_cmp();
    key_chk(KEY_NEG, "neg_at_fall", 16'h03A8, 1, 0, 0);

    // Multiply chained by an op key, then continued
    press(KEY_CLR);
    press(5'h03); press(KEY_MUL);
    press(5'h04);
    key_chk(KEY_ADD, "mulchain_op", 16'h0004, 0, 0, 1);
    push_exp("mulchain_res", 16'h000C, 0, 0, 0);
    run_mul(-1, cyc);
    pop_cmp();
    press(5'h05);
    key_chk(KEY_EQ,  "mulchain_eq", 16'h0011, 0, 0, 0);

    // Multiply overflow with a negative operand gives zero, ovw=1, sign=0
    press(KEY_CLR);
    press(5'h01); press(5'h00); press(5'h00);
    key_chk(KEY_NEG, "mulovf_neg", 16'h0100, 1, 0, 0);
    press(KEY_MUL);
    press(5'h02); press(5'h00); press(5'h00);
    press(KEY_EQ);
    push_exp("mulovf_res", 16'h0000, 0, 1, 0);
    run_mul(-1, cyc);
    pop_cmp();

    // Add chaining
    press(KEY_CLR);
    press(5'h02); press(KEY_ADD); press(5'h03);
    key_chk(KEY_ADD, "chain_op", 16'h0005, 0, 0, 0);
    press(5'h04);
    key_chk(KEY_EQ,  "chain_eq", 16'h0009, 0, 0, 0);

    // Entry limit and an ignored keycode
    press(KEY_CLR);
    press(5'h01); press(5'h02); press(5'h03); press(5'h04);
    key_chk(5'h05,   "limit",    16'h1234, 0, 0, 0);
    key_chk(5'h16,   "ignored",  16'h1234, 0, 0, 0);

    // Random add/sub against an integer model
    for (int it = 0; it < 8; it++) begin
      am  = 16'($urandom);
      bm  = 16'($urandom);
      an  = 1'($urandom);
      bn  = 1'($urandom);
      sub = 1'($urandom);
      press(KEY_CLR);
      type_hex(am);
      if (an) press(KEY_NEG);
      press(sub ? KEY_SUB : KEY_ADD);
      type_hex(bm);
      if (bn) press(KEY_NEG);
      av  = an ? -int'(am) : int'(am);
      bv  = bn ? -int'(bm) : int'(bm);
      rv  = sub ? av - bv : av + bv;
      mag = (rv < 0) ? -rv : rv;
      eo  = (mag > 65535);
      em  = 16'(mag);
      es  = (rv < 0) && (em != 16'h0000);
      key_chk(KEY_EQ, $sformatf("rand%0d", it), em, es, eo, 0);
    end

    // Asynchronous reset mid-multiply, then recovery
    press(KEY_CLR);
    press(5'h01); press(5'h02); press(KEY_MUL); press(5'h03); press(5'h04);
    press(KEY_EQ);
    repeat (4) @(negedge clk);
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_display", 32'(bus.display), 32'h0);
    check("rst_sign",    32'(bus.sign),    32'h0);
    check("rst_ovw",     32'(bus.ovw),     32'h0);
    check("rst_busy",    32'(bus.busy),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    press(5'h01); press(KEY_ADD); press(5'h01);
    key_chk(KEY_EQ, "post_reset", 16'h0002, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
